// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared constants and types for the CPU common bus.
// Source codes match the selector encoding of the original hardwired bus mux.
package cpu_bus_pkg;

   localparam int DEF_WIDTH = 16;

   localparam int SRC_AR  = 1;
   localparam int SRC_PC  = 2;
   localparam int SRC_DR  = 3;
   localparam int SRC_AC  = 4;
   localparam int SRC_IR  = 5;
   localparam int SRC_TR  = 6;
   localparam int SRC_MEM = 7;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } bus_state_e;

endpackage

// File: rtl/bus_arb_pick.sv
// bus_arb_pick: combinational winner selection, scanning upward from rr_ptr with wrap.
// A zero rr_ptr gives plain lowest-index priority.
module bus_arb_pick
   import cpu_bus_pkg::*;
#(
   parameter int N_SRC = 8,
   parameter int IDW   = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] req,
   input  logic [N_SRC-1:0] excl,
   input  logic [IDW-1:0]   rr_ptr,
   output logic [N_SRC-1:0] win_onehot,
   output logic [IDW-1:0]   win_idx,
   output logic             win_any
);

   logic [N_SRC-1:0] elig_s;

   assign elig_s = req & ~excl;

   // First eligible requester at or after rr_ptr wins.
   always_comb begin
      logic [IDW-1:0] cand_s;
      win_onehot = '0;
      win_idx    = '0;
      win_any    = 1'b0;
      cand_s     = '0;
      for (int k = 0; k < N_SRC; k++) begin
         cand_s = IDW'((int'(rr_ptr) + k) % N_SRC);
         if (!win_any && elig_s[cand_s]) begin
            win_any            = 1'b1;
            win_idx            = cand_s;
            win_onehot[cand_s] = 1'b1;
         end else begin
            win_any = win_any;
         end
      end
   end

endmodule

// File: rtl/common_bus_arb.sv
// common_bus_arb: registered common-bus multiplexer with request/grant arbitration and bounded lock.
// Define COMMON_BUS_RR_EN for round-robin arbitration; otherwise fixed lowest-index priority.
module common_bus_arb
   import cpu_bus_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int N_SRC    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_SRC-1:0]           req,
   input  logic [N_SRC-1:0]           lock,
   input  logic [N_SRC*WIDTH-1:0]     src_data,
   output logic [WIDTH-1:0]           bus,
   output logic                       bus_valid,
   output logic [N_SRC-1:0]           grant,
   output logic [$clog2(N_SRC)-1:0]   grant_id,
   output logic                       hold_timeout
);

   localparam int IDW = $clog2(N_SRC);
   localparam int HCW = $clog2(MAX_HOLD + 1);

   bus_state_e       state_r;
   logic [N_SRC-1:0] grant_r;
   logic [IDW-1:0]   owner_r;
   logic [WIDTH-1:0] bus_r;
   logic             bus_valid_r;
   logic             hold_timeout_r;
   logic [HCW-1:0]   hold_cnt_r;

   logic             retain_req_s;
   logic             others_s;
   logic             fire_s;
   logic             retain_s;
   logic [N_SRC-1:0] excl_s;
   logic [IDW-1:0]   rr_ptr_s;
   logic [N_SRC-1:0] win_onehot_s;
   logic [IDW-1:0]   win_idx_s;
   logic             win_any_s;
   logic [IDW-1:0]   sel_idx_s;
   logic [WIDTH-1:0] src_arr_s [N_SRC];

   for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
      assign src_arr_s[i] = src_data[i*WIDTH +: WIDTH];
   end

   // Owner wants to keep the bus; lock is meaningless without req.
   always_comb begin
      if (state_r == OWNED) begin
         retain_req_s = req[owner_r] & lock[owner_r];
      end else begin
         retain_req_s = 1'b0;
      end
   end

   // Hold limit only breaks a lock when somebody else is actually waiting.
   assign others_s  = |(req & ~grant_r);
   assign fire_s    = retain_req_s && (hold_cnt_r == HCW'(MAX_HOLD)) && others_s;
   assign retain_s  = retain_req_s && !fire_s;
   assign excl_s    = fire_s ? grant_r : '0;
   assign sel_idx_s = retain_s ? owner_r : win_idx_s;

   bus_arb_pick #(
      .N_SRC (N_SRC),
      .IDW   (IDW)
   ) u_pick (
      .req        (req),
      .excl       (excl_s),
      .rr_ptr     (rr_ptr_s),
      .win_onehot (win_onehot_s),
      .win_idx    (win_idx_s),
      .win_any    (win_any_s)
   );

`ifdef COMMON_BUS_RR_EN
   logic [IDW-1:0] rr_ptr_r;

   // Round-robin pointer moves just past every newly granted owner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r <= '0;
      end else if (!retain_s && win_any_s) begin
         rr_ptr_r <= (win_idx_s == IDW'(N_SRC - 1)) ? '0 : win_idx_s + IDW'(1);
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

   assign rr_ptr_s = rr_ptr_r;
`else
   assign rr_ptr_s = '0;
`endif

   // Ownership FSM with registered bus and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         grant_r        <= '0;
         owner_r        <= '0;
         bus_r          <= '0;
         bus_valid_r    <= 1'b0;
         hold_timeout_r <= 1'b0;
         hold_cnt_r     <= '0;
      end else begin
         hold_timeout_r <= fire_s;
         case (state_r)
            IDLE: begin
               if (win_any_s) begin
                  state_r     <= OWNED;
                  grant_r     <= win_onehot_s;
                  owner_r     <= win_idx_s;
                  bus_r       <= src_arr_s[sel_idx_s];
                  bus_valid_r <= 1'b1;
                  hold_cnt_r  <= '0;
               end else begin
                  state_r     <= IDLE;
                  grant_r     <= '0;
                  bus_valid_r <= 1'b0;
                  hold_cnt_r  <= '0;
               end
            end
            OWNED: begin
               if (retain_s) begin
                  bus_r <= src_arr_s[sel_idx_s];
                  if (hold_cnt_r != HCW'(MAX_HOLD)) begin
                     hold_cnt_r <= hold_cnt_r + HCW'(1);
                  end else begin
                     hold_cnt_r <= hold_cnt_r;
                  end
               end else if (win_any_s) begin
                  // Hand over on the same edge, no idle bubble.
                  state_r     <= OWNED;
                  grant_r     <= win_onehot_s;
                  owner_r     <= win_idx_s;
                  bus_r       <= src_arr_s[sel_idx_s];
                  bus_valid_r <= 1'b1;
                  hold_cnt_r  <= '0;
               end else begin
                  state_r     <= IDLE;
                  grant_r     <= '0;
                  bus_valid_r <= 1'b0;
                  hold_cnt_r  <= '0;
               end
            end
            default: begin
               state_r     <= IDLE;
               grant_r     <= '0;
               bus_valid_r <= 1'b0;
               hold_cnt_r  <= '0;
            end
         endcase
      end
   end

   assign bus          = bus_r;
   assign bus_valid    = bus_valid_r;
   assign grant        = grant_r;
   assign grant_id     = owner_r;
   assign hold_timeout = hold_timeout_r;

endmodule

// File: tb/tb_common_bus_arb.sv
// tb_common_bus_arb: directed plus randomized checks of common_bus_arb against a behavioural model.
// The model follows COMMON_BUS_RR_EN the same way the design does.
module tb_common_bus_arb;

   localparam int W  = 16;
   localparam int N  = 8;
   localparam int MH = 4;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N-1:0]   lock;
   logic [N*W-1:0] src_data;
   logic [W-1:0]   bus;
   logic           bus_valid;
   logic [N-1:0]   grant;
   logic [2:0]     grant_id;
   logic           hold_timeout;

   int n_checks = 0;
   int n_pass   = 0;

   int         m_owner;
   int         m_hold;
   int         m_rr;
   logic [W-1:0] m_bus;
   bit         m_valid;
   bit         m_to;

   common_bus_arb #(.WIDTH(W), .N_SRC(N), .MAX_HOLD(MH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .lock         (lock),
      .src_data     (src_data),
      .bus          (bus),
      .bus_valid    (bus_valid),
      .grant        (grant),
      .grant_id     (grant_id),
      .hold_timeout (hold_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [W-1:0] data_of(input int i);
      return src_data[i*W +: W];
   endfunction

   task automatic set_data(input int i, input logic [W-1:0] v);
      src_data[i*W +: W] = v;
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_hold  = 0;
      m_rr    = 0;
      m_bus   = '0;
      m_valid = 0;
      m_to    = 0;
   endtask

   // One clock edge of the arbitration rules, using inputs as they stand at the edge.
   task automatic model_step();
      int  excl;
      bit  keep;
      int  w;
      int  start;
      excl = -1;
      keep = 0;
      m_to = 0;
      if (m_owner >= 0 && req[m_owner] && lock[m_owner]) begin
         if (m_hold == MH && (req & ~(8'd1 << m_owner)) != 8'd0) begin
            m_to = 1;
            excl = m_owner;
         end else begin
            keep = 1;
         end
      end
      if (keep) begin
         m_bus = data_of(m_owner);
         if (m_hold < MH) m_hold++;
      end else begin
`ifdef COMMON_BUS_RR_EN
         start = m_rr;
`else
         start = 0;
`endif
         w = -1;
         for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (w < 0 && req[i] && i != excl) w = i;
         end
         if (w >= 0) begin
            m_owner = w;
            m_bus   = data_of(w);
            m_valid = 1;
            m_hold  = 0;
            m_rr    = (w + 1) % N;
         end else begin
            m_owner = -1;
            m_valid = 0;
            m_hold  = 0;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      logic [N-1:0] eg;
      eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
      check_eq({tag, ".bus"}, 32'(bus), 32'(m_bus));
      check_eq({tag, ".valid"}, 32'(bus_valid), 32'(m_valid));
      check_eq({tag, ".grant"}, 32'(grant), 32'(eg));
      check_eq({tag, ".timeout"}, 32'(hold_timeout), 32'(m_to));
      if (m_valid) check_eq({tag, ".grant_id"}, 32'(grant_id), 32'(m_owner));
   endtask

   // Inputs are changed on the falling edge; the model advances on the rising edge.
   task automatic step(input string tag);
      @(posedge clk);
      model_step();
      #1;
      compare_all(tag);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      req      = '0;
      lock     = '0;
      src_data = '0;
      model_reset();
      @(negedge clk);
      do_reset();

      check_eq("rst.bus", 32'(bus), 32'h0);
      check_eq("rst.valid", 32'(bus_valid), 32'h0);
      check_eq("rst.grant", 32'(grant), 32'h0);
      check_eq("rst.grant_id", 32'(grant_id), 32'h0);
      check_eq("rst.timeout", 32'(hold_timeout), 32'h0);

      // Single request from source 3.
      set_data(3, 16'h1234);
      req = 8'h08;
      step("t1");
      check_eq("t1.id3", 32'(grant_id), 32'd3);
      check_eq("t1.bus1234", 32'(bus), 32'h1234);

      // Two requesters, no lock.
      set_data(1, 16'h0111);
      req = 8'h0A;
      for (int k = 0; k < 4; k++) begin
         step("t2");
`ifdef COMMON_BUS_RR_EN
         check_eq("t2.alt", 32'(grant_id), (k % 2 == 0) ? 32'd1 : 32'd3);
`else
         check_eq("t2.fixed", 32'(grant_id), 32'd1);
`endif
      end

      // Locked owner with changing data.
      req  = 8'h10;
      lock = 8'h10;
      set_data(4, 16'hAAAA);
      step("t3a");
      set_data(4, 16'h5555);
      step("t3b");
      check_eq("t3.follow", 32'(bus), 32'h5555);
      check_eq("t3.owner", 32'(grant), 32'h10);

      // Release with nothing pending keeps last bus value.
      req  = 8'h00;
      lock = 8'h00;
      step("t4");
      check_eq("t4.valid0", 32'(bus_valid), 32'h0);
      check_eq("t4.hold_bus", 32'(bus), 32'h5555);

      // Hold limit: source 2 locked while source 5 waits.
      set_data(2, 16'h2222);
      set_data(5, 16'h5A5A);
      req  = 8'h04;
      lock = 8'h04;
      step("t5g");
      req = 8'h24;
      for (int k = 0; k < MH; k++) step("t5h");
      check_eq("t5.still2", 32'(grant), 32'h04);
      step("t5f");
      check_eq("t5.pulse", 32'(hold_timeout), 32'h1);
      check_eq("t5.grant5", 32'(grant), 32'h20);
      req  = 8'h20;
      lock = 8'h20;
      step("t5n");
      check_eq("t5.pulse1", 32'(hold_timeout), 32'h0);

      // Asynchronous reset in the middle of a locked transfer.
      step("t6l");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("t6.bus", 32'(bus), 32'h0);
      check_eq("t6.valid", 32'(bus_valid), 32'h0);
      check_eq("t6.grant", 32'(grant), 32'h0);
      check_eq("t6.grant_id", 32'(grant_id), 32'h0);
      check_eq("t6.timeout", 32'(hold_timeout), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      req   = 8'h40;
      lock  = 8'h00;
      set_data(6, 16'h6006);
      step("t6r");
      check_eq("t6.fresh", 32'(grant), 32'h40);

      // Randomized traffic; requests and locks often persist to exercise the hold limit.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            req  = 8'($urandom & $urandom);
            lock = 8'($urandom);
         end
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1) set_data(i, 16'($urandom));
         end
         step("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/common_bus_arb.md
# common_bus_arb

Registered, parametrised common-bus multiplexer with request/grant arbitration. It succeeds the fixed 3-bit-selector bus mux used in the hardwired CPU datapath. N_SRC register and memory sources each raise a request. The block picks one owner, drives that owner's data onto a registered `bus`, and keeps ownership across multi-cycle transfers with a bounded lock. It sits between the datapath registers (AR, PC, DR, AC, IR, TR, memory) and all bus loads, and replaces the control unit's selector encoding with per-source requests.

## Interface
Parameters:
- `WIDTH`, 16: bus width in bits. Narrower sources (AR, PC) are zero-extended by the caller.
- `N_SRC`, 8: number of sources, minimum 2.
- `MAX_HOLD`, 4: maximum consecutive locked cycles while another source waits, minimum 1.

Ports:
- `clk` in 1: the single clock. All logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N_SRC: per-source bus request.
- `lock` in N_SRC: per-source request to keep ownership past the current cycle.
- `src_data` in N_SRC*WIDTH: flattened source data. Source i occupies bits [i*WIDTH +: WIDTH].
- `bus` out WIDTH: registered bus value.
- `bus_valid` out 1: `bus` holds data driven by a granted owner this cycle.
- `grant` out N_SRC: one-hot owner, or all zero.
- `grant_id` out clog2(N_SRC): index of the owner. Valid only while `bus_valid`.
- `hold_timeout` out 1: one-cycle pulse when a lock is forcibly broken.

## Operation
- FSM states:
  - IDLE: no owner.
  - OWNED: `grant` is non-zero.
- Arbitration runs at every edge in IDLE, and at every edge in OWNED where the owner does not retain the bus.
- The owner retains the bus at an edge when `req[owner]` and `lock[owner]` are both 1 and the hold limit has not fired.
- Winner selection:
  - Default (fixed priority): the lowest requesting index wins.
  - With round-robin (see Configuration): the first requester at or after `rr_ptr`, wrapping from N_SRC-1 to 0. `rr_ptr` is set to winner+1 mod N_SRC at every new grant.
- On a grant edge: `grant` and `grant_id` are set to the winner, `bus <= src_data[winner]`, `bus_valid <= 1`, state goes to OWNED, `hold_cnt <= 0`.
- While retained:
  - `bus` reloads from `src_data[owner]` every edge.
  - `hold_cnt` increments and saturates at MAX_HOLD.
- Release with no requests: state goes to IDLE, `grant` = 0, `bus_valid` = 0, `bus` holds its last value (no latch, no X).
- Release with other requests pending: the next owner is granted on the same edge, with no idle bubble.
- Hold limit:
  - Fires when `hold_cnt == MAX_HOLD`, the owner is retaining, and any other `req` is 1.
  - On that edge the current owner is excluded from arbitration and `hold_timeout` pulses for 1 cycle.
  - If no other source requests, the owner keeps the bus indefinitely and no pulse occurs.
- `lock` without `req` is ignored.
- A source's `req` and `lock` changing on the same edge are both sampled at that edge.

## Timing
- Reset values: `bus` = 0, `bus_valid` = 0, `grant` = 0, `grant_id` = 0, `hold_timeout` = 0, state IDLE, `rr_ptr` = 0, `hold_cnt` = 0.
- Latency: `req` sampled at edge E gives `grant` and `bus` valid after E, a 1-cycle registered latency.
- `src_data` of the owner is sampled at every edge while it owns the bus.
- Reset asserted mid-transfer clears all outputs immediately, asynchronously.
- After `rst_n` rises, the first grant occurs at the first edge with any `req` set.
- Simultaneous requests resolve entirely within one edge. `grant` is never multi-hot.

## Configuration
- `COMMON_BUS_RR_EN`:
  - Defined: round-robin arbitration with the `rr_ptr` register.
  - Undefined: fixed lowest-index priority. `rr_ptr` is not instantiated.
- Lock, hold limit, and all ports are identical in both builds.

## Structure
- Shared package `cpu_bus_pkg` holds:
  - source index constants SRC_AR = 1 through SRC_MEM = 7, matching the existing selector codes;
  - the state enum {IDLE, OWNED};
  - default WIDTH = 16.
- One sub-module, `bus_arb_pick`: purely combinational winner selection from `req`, exclude mask, and `rr_ptr`. It outputs a one-hot vector and an index, and is unit-testable alone.

## Test plan
- Reset, then `req` = 0x08 with `src_data[3]` = 0x1234 → after 1 edge `grant` = 0x08, `grant_id` = 3, `bus` = 0x1234, `bus_valid` = 1.
- `req` = 0x0A held, no lock:
  - fixed priority → `grant_id` = 1 on every edge;
  - RR build → grants alternate 1, 3, 1, 3.
- Source 4 holds `req` + `lock` while `src_data[4]` changes 0xAAAA → 0x5555 mid-transfer → `bus` follows one cycle later and ownership is retained.
- Source 2 locked, source 5 requests, MAX_HOLD = 4 → after the 4th retained edge `hold_timeout` = 1 for 1 cycle and `grant` = 0x20.
- Owner drops `req` with none pending → `bus_valid` = 0, `grant` = 0, `bus` keeps its last value 0x5555.
- Assert `rst_n` = 0 mid-lock between edges → all outputs are 0 before the next edge, and the first grant after release honours the fresh `req`.
